// File: rtl/axi_modport_pkg.sv
// Shared types and constants for the memory-backed AXI slave.
// Burst, response and FSM state encodings live here so both paths agree.
package axi_modport_pkg;

  localparam int MEM_DEPTH  = 256;
  localparam int ADDR_LIMIT = 1024;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_modport_addr_gen.sv
// Beat address sequencer: next beat address plus error flag for the current beat.
// WRAP support is compiled in only when AXI_MODPORT_WRAP_EN is defined.
module axi_modport_addr_gen
  import axi_modport_pkg::*;
#(
  parameter int AWIDTH = 32
) (
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [AWIDTH-1:0] next_addr_o,
  output logic              err_o
);

  logic [AWIDTH-1:0] step;
  logic [AWIDTH-1:0] incr_addr;
  logic              burst_err;
`ifdef AXI_MODPORT_WRAP_EN
  logic [AWIDTH-1:0] wrap_mask;
  logic [AWIDTH-1:0] wrap_addr;
`else
  logic              len_unused;
  assign len_unused = ^len_i;
`endif

  always_comb begin
    step      = AWIDTH'(1) << size_i;
    incr_addr = addr_i + step;
`ifdef AXI_MODPORT_WRAP_EN
    // Wrap block is (LEN+1)<<SIZE bytes; only the in-block offset advances.
    wrap_mask = ((AWIDTH'(len_i) + AWIDTH'(1)) << size_i) - AWIDTH'(1);
    wrap_addr = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
    next_addr_o = addr_i;
    burst_err   = 1'b0;
    case (burst_e'(burst_i))
      FIXED: next_addr_o = addr_i;
      INCR:  next_addr_o = incr_addr;
`ifdef AXI_MODPORT_WRAP_EN
      WRAP: begin
        next_addr_o = wrap_addr;
        burst_err   = !wrap_len_ok(len_i);
      end
`endif
      default: burst_err = 1'b1;
    endcase
    err_o = burst_err || (size_i > 3'd2) || (addr_i >= AWIDTH'(ADDR_LIMIT));
  end

endmodule

// File: rtl/axi_modport_slave.sv
// Memory-backed AXI3 slave (256 x 32-bit) with independent single-burst read and write paths.
// Define AXI_MODPORT_WRAP_EN to accept WRAP bursts; otherwise they answer SLVERR.
module axi_modport_slave
  import axi_modport_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int WIDTH  = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [3:0]        AWID,
  input  logic [AWIDTH-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [3:0]        WID,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic [WIDTH/8-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [3:0]        BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [3:0]        ARID,
  input  logic [AWIDTH-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [3:0]        RID,
  output logic [WIDTH-1:0]  RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);

  logic [WIDTH-1:0] mem [MEM_DEPTH];

  logic              wid_unused;
  assign wid_unused = ^WID;

  wstate_e           w_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [3:0]        bid_q;
  resp_e             bresp_q;
  logic [AWIDTH-1:0] waddr_q, w_next;
  logic [7:0]        wlen_q, wcnt_q;
  logic [2:0]        wsize_q;
  logic [1:0]        wburst_q;
  logic              w_err, mem_we;

  axi_modport_addr_gen #(.AWIDTH(AWIDTH)) u_wr_agen (
    .addr_i(waddr_q), .len_i(wlen_q), .size_i(wsize_q), .burst_i(wburst_q),
    .next_addr_o(w_next), .err_o(w_err)
  );

  assign mem_we = wready_q && WVALID && !w_err;

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (WSTRB[b]) mem[waddr_q[9:2]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && AWVALID) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= AWID;
            waddr_q   <= AWADDR;
            wlen_q    <= AWLEN;
            wsize_q   <= AWSIZE;
            wburst_q  <= AWBURST;
            wcnt_q    <= '0;
            bresp_q   <= OKAY;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            // Response is sticky: any bad beat or misplaced WLAST poisons the burst.
            if (w_err || (WLAST != (wcnt_q == wlen_q))) bresp_q <= SLVERR;
            if (wcnt_q == wlen_q) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              w_state_q <= W_RESP;
            end else begin
              waddr_q <= w_next;
              wcnt_q  <= wcnt_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  rstate_e           r_state_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [3:0]        rid_q;
  resp_e             rresp_q;
  logic [WIDTH-1:0]  rdata_q;
  logic [AWIDTH-1:0] raddr_q, r_addr_d, r_next;
  logic [7:0]        rlen_q, rcnt_q, r_len_d;
  logic [2:0]        rsize_q, r_size_d;
  logic [1:0]        rburst_q, r_burst_d;
  logic              r_err;

  // In idle the generator looks at the AR channel so beat 0 is ready one edge after the handshake.
  always_comb begin
    r_addr_d  = raddr_q;
    r_len_d   = rlen_q;
    r_size_d  = rsize_q;
    r_burst_d = rburst_q;
    if (r_state_q == R_IDLE) begin
      r_addr_d  = ARADDR;
      r_len_d   = ARLEN;
      r_size_d  = ARSIZE;
      r_burst_d = ARBURST;
    end
  end

  axi_modport_addr_gen #(.AWIDTH(AWIDTH)) u_rd_agen (
    .addr_i(r_addr_d), .len_i(r_len_d), .size_i(r_size_d), .burst_i(r_burst_d),
    .next_addr_o(r_next), .err_o(r_err)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else if (r_state_q == R_IDLE) begin
      arready_q <= 1'b1;
      if (arready_q && ARVALID) begin
        arready_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rid_q     <= ARID;
        rlen_q    <= ARLEN;
        rsize_q   <= ARSIZE;
        rburst_q  <= ARBURST;
        raddr_q   <= r_next;
        rcnt_q    <= '0;
        rlast_q   <= (ARLEN == 8'd0);
        rresp_q   <= r_err ? SLVERR : OKAY;
        rdata_q   <= r_err ? '0 : mem[r_addr_d[9:2]];
        r_state_q <= R_DATA;
      end
    end else if (RREADY) begin
      if (rlast_q) begin
        rvalid_q  <= 1'b0;
        rlast_q   <= 1'b0;
        arready_q <= 1'b1;
        r_state_q <= R_IDLE;
      end else begin
        rresp_q <= r_err ? SLVERR : OKAY;
        rdata_q <= r_err ? '0 : mem[r_addr_d[9:2]];
        raddr_q <= r_next;
        rcnt_q  <= rcnt_q + 8'd1;
        rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_modport_slave.sv
// Directed bench for axi_modport_slave: reset, INCR/partial/WRAP/out-of-range/stalled bursts.
// WRAP expectations follow AXI_MODPORT_WRAP_EN.
module tb_axi_modport_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_data  [16];
  logic [31:0] exp_data [16];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  always #5 ACLK = ~ACLK;

  axi_modport_slave #(.AWIDTH(32), .WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb);
    int n;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    chk("awready", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("wready_after_aw", WREADY, 1);
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wr_data[i]; WSTRB = strb; WLAST = (i == int'(len)); WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("bvalid_after_last", BVALID, 1);
    chk("wready_drop", WREADY, 0);
    @(negedge ACLK);
    chk("bvalid_hold", BVALID, 1);
    BREADY = 1'b1;
    b_resp = BRESP; b_id = BID;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("bvalid_clear", BVALID, 0);
    chk("awready_return", AWREADY, 1);
    $display("write id=%0d addr=%h len=%0d burst=%0d bresp=%0d bid=%0d", id, addr, len, burst, b_resp, b_id);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit stall,
                          input logic [1:0] exp_resp);
    int n;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    chk("arready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (stall) begin
        RREADY = 1'b0;
        @(negedge ACLK);
        chk("rvalid_stall", RVALID, 1);
        chk("rdata_stall", RDATA, exp_data[i]);
      end
      RREADY = 1'b1;
      chk("rvalid", RVALID, 1);
      chk("rdata", RDATA, exp_data[i]);
      chk("rresp", RRESP, exp_resp);
      chk("rlast", RLAST, (i == int'(len)));
      chk("rid", RID, id);
      @(negedge ACLK);
    end
    RREADY = 1'b0;
    chk("rvalid_end", RVALID, 0);
    $display("read id=%0d addr=%h len=%0d burst=%0d stall=%0d", id, addr, len, burst, stall);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ARESETn = 1'b0;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
    WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
    repeat (3) @(negedge ACLK);

    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_ids", {BID, RID}, 0);
    chk("rst_resps", {BRESP, RRESP}, 0);
    chk("rst_rdata", RDATA, 0);
    ARESETn = 1'b1;
    #1;
    chk("rel_awready_low", AWREADY, 0);
    @(negedge ACLK);
    chk("rel_awready", AWREADY, 1);
    chk("rel_arready", ARREADY, 1);
    $display("reset released");

    // INCR burst write and readback
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + i;
    axi_write(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 4'hF);
    chk("incr_bresp", b_resp, 2'b00);
    chk("incr_bid", b_id, 4'd5);
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hA0 + i;
    axi_read(4'd9, 32'h10, 8'd3, 3'd2, 2'b01, 1'b0, 2'b00);

    // Partial strobe
    wr_data[0] = 32'hFFFF_FFFF;
    axi_write(4'd1, 32'h80, 8'd0, 3'd2, 2'b01, 4'hF);
    chk("full_bresp", b_resp, 2'b00);
    wr_data[0] = 32'h1234_5678;
    axi_write(4'd2, 32'h80, 8'd0, 3'd2, 2'b01, 4'b0101);
    chk("partial_bresp", b_resp, 2'b00);
    exp_data[0] = 32'hFF34_FF78;
    axi_read(4'd3, 32'h80, 8'd0, 3'd2, 2'b01, 1'b0, 2'b00);

    // WRAP over a pre-filled 16-byte block at 0x30
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hB0 + i;
    axi_write(4'd4, 32'h30, 8'd3, 3'd2, 2'b01, 4'hF);
    chk("prefill_bresp", b_resp, 2'b00);
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hC0 + i;
    axi_write(4'd6, 32'h38, 8'd3, 3'd2, 2'b10, 4'hF);
`ifdef AXI_MODPORT_WRAP_EN
    chk("wrap_bresp", b_resp, 2'b00);
    exp_data[0] = 32'hC2; exp_data[1] = 32'hC3; exp_data[2] = 32'hC0; exp_data[3] = 32'hC1;
    axi_read(4'd7, 32'h30, 8'd3, 3'd2, 2'b01, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hC0 + i;
    axi_read(4'd8, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0, 2'b00);
`else
    chk("wrap_bresp", b_resp, 2'b10);
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hB0 + i;
    axi_read(4'd7, 32'h30, 8'd3, 3'd2, 2'b01, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) exp_data[i] = 32'h0;
    axi_read(4'd8, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0, 2'b10);
`endif

    // Out of range: 0x400 would alias word 0 if the range check were missing
    wr_data[0] = 32'h1111_1111;
    axi_write(4'd10, 32'h0, 8'd0, 3'd2, 2'b01, 4'hF);
    chk("w0_bresp", b_resp, 2'b00);
    wr_data[0] = 32'hDEAD_BEEF;
    axi_write(4'd11, 32'h400, 8'd0, 3'd2, 2'b01, 4'hF);
    chk("oor_bresp", b_resp, 2'b10);
    chk("oor_bid", b_id, 4'd11);
    exp_data[0] = 32'h1111_1111;
    axi_read(4'd12, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0, 2'b00);
    exp_data[0] = 32'h0;
    axi_read(4'd13, 32'h400, 8'd0, 3'd2, 2'b01, 1'b0, 2'b10);

    // Oversized beat is an error
    wr_data[0] = 32'h5555_5555;
    axi_write(4'd14, 32'h20, 8'd0, 3'd3, 2'b01, 4'hF);
    chk("size_bresp", b_resp, 2'b10);

    // LEN=7 read with RREADY toggling every other cycle
    for (int i = 0; i < 8; i++) wr_data[i] = 32'hD0 + i;
    axi_write(4'd15, 32'h100, 8'd7, 3'd2, 2'b01, 4'hF);
    chk("stall_wr_bresp", b_resp, 2'b00);
    for (int i = 0; i < 8; i++) exp_data[i] = 32'hD0 + i;
    axi_read(4'd2, 32'h100, 8'd7, 3'd2, 2'b01, 1'b1, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_modport_slave.md
# axi_modport_slave

AXI3-style memory-backed slave presenting the slave side of the team's AXI interface (`slave_mp` signal set). It accepts bursts on the AW/W/B and AR/R channels and services them from a 256 x 32-bit internal memory. Read and write paths run independently, and each handles one outstanding burst at a time. The block is the reference endpoint for master-side verification.

## Interface
- AWIDTH, 32, address width
- WIDTH, 32, data width (only 32 supported); WSTRB width = WIDTH/8
- ACLK in 1: clock, all logic on rising edge
- ARESETn in 1: reset, asynchronous, active-low; clock ACLK
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID in 4/AWIDTH/8/3/2/1: write address channel
- AWREADY out 1: write address accept
- WID/WDATA/WSTRB/WLAST/WVALID in 4/WIDTH/WIDTH/8/1/1: write data (WID ignored)
- WREADY out 1: write data accept
- BID/BRESP/BVALID out 4/2/1; BREADY in 1: write response
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID in 4/AWIDTH/8/3/2/1: read address channel
- ARREADY out 1: read address accept
- RID/RDATA/RRESP/RLAST/RVALID out 4/WIDTH/2/1/1; RREADY in 1: read data

## Operation
- Memory word index = addr[9:2]; addr >= 1024 is out of range.
- Beat address: FIXED (00) constant; INCR (01) += 1<<SIZE; WRAP (10) wraps within an aligned block of (LEN+1)<<SIZE bytes. Burst 11 is reserved.
- Error conditions give SLVERR (2'b10), else OKAY (2'b00):
  - SIZE > 2
  - reserved burst type
  - WRAP with LEN not in {1,3,7,15}
  - any beat out of range
- Error handling:
  - Erroneous write beats do not modify memory.
  - Erroneous read beats return RDATA=0.
  - BRESP is sticky-OR over all beats of the burst.
- Write FSM:
  - W_IDLE (AWREADY=1) -> W_DATA on AW handshake; latch ID/addr/len/size/burst.
  - W_DATA (WREADY=1): each W handshake writes bytes enabled by WSTRB.
  - After LEN+1 beats -> W_RESP. WLAST not asserted exactly on beat LEN forces SLVERR.
  - W_RESP (BVALID=1, BID=latched AWID) -> W_IDLE on BREADY.
- Read FSM:
  - R_IDLE (ARREADY=1) -> R_DATA on AR handshake.
  - R_DATA (RVALID=1, RID=ARID): advance on RREADY. RLAST=1 on beat ARLEN, then -> R_IDLE.
- Simultaneous read and write to the same word on the same edge: read returns the old data.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values:
  - AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0
  - BID/RID/BRESP/RRESP/RDATA = 0
  - FSMs go to IDLE; AWREADY/ARREADY assert on the first edge after reset release.
- AW handshake at edge N: WREADY=1 from N+1. WREADY is deasserted the cycle after the last beat.
- Last W beat at edge N: BVALID=1 from N+1, held with stable BID/BRESP until BREADY. AWREADY returns the cycle after the B handshake.
- AR handshake at edge N: RVALID with beat 0 from N+1. Back-to-back beats have no bubble while RREADY=1. Outputs are held stable while RREADY=0.
- AXI rule honoured: VALID never depends combinationally on READY. All outputs are registered.
- Reset asserted mid-burst aborts immediately. Memory writes already performed remain.

## Configuration
- AXI_MODPORT_WRAP_EN:
  - Defined: WRAP bursts are supported as above.
  - Undefined: WRAP is treated as reserved. Every beat returns SLVERR with no memory update.

## Structure
- Package axi_modport_pkg holds:
  - burst_e (FIXED/INCR/WRAP)
  - resp_e (OKAY/EXOKAY/SLVERR/DECERR)
  - write and read FSM state enums
  - MEM_DEPTH=256 constant
- Sub-module axi_modport_addr_gen (addr, len, size, burst -> next addr, error flag) is shared by the write and read paths.

## Test plan
- Reset: hold ARESETn=0 -> all VALID/READY outputs 0. After release, AWREADY=1 and ARREADY=1 on the next edge.
- INCR write AWADDR=0x10, LEN=3, SIZE=2, data 0xA0..0xA3, WSTRB=F -> BRESP=OKAY, BID=AWID. INCR read of the same burst returns 0xA0..0xA3 with RLAST on beat 3.
- Partial strobe: write 0xFFFFFFFF, then 0x12345678 with WSTRB=0101 -> readback 0xFF34FF78.
- WRAP LEN=3 at addr 0x38 -> beats hit 0x38, 0x3C, 0x30, 0x34. Without the macro -> SLVERR and memory unchanged.
- Out-of-range write at 0x400 -> BRESP=SLVERR. Read at 0x400 -> RRESP=SLVERR, RDATA=0.
- RREADY toggled every other cycle during a LEN=7 read -> no lost or duplicated beats, RDATA stable while stalled.
